vend_dispenser: RTL

Mechanical-side responder for the vending controller: consumes the one-cycle `sell`/`change` result pulses the coin FSM emits, queues them, and sequences the product motor, drop-sensor check and 5-cent change hopper for each order. Orders arriving while a vend is in progress are buffered in a small FIFO. A drop-sensor timeout raises a latched fault that software clears. The block sits between the coin FSM outputs and the actuator/sensor pins.

---
 rtl/vend_dispenser.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/vend_dispenser.sv
// Order queue and actuator sequencer behind the coin FSM: buffers sell pulses and drives
// motor, drop-sensor wait and change hopper per order. Define DISPENSER_REFUND_EN to refund on timeout.
module vend_dispenser #(
    parameter int DEPTH     = 4,
    parameter int MOTOR_CYC = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sell,
    input  logic                     change,
    input  logic                     item_drop,
    input  logic                     fault_clr,
    output logic                     motor,
    output logic                     coin_out,
    output logic                     busy,
    output logic                     fault,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (MOTOR_CYC > TIMEOUT) ? MOTOR_CYC : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 10) + 1;

`ifdef DISPENSER_REFUND_EN
    typedef enum logic [2:0] {IDLE, VEND, WAIT_DROP, CHANGE, REFUND, FAULT} state_t;
`else
    typedef enum logic [2:0] {IDLE, VEND, WAIT_DROP, CHANGE, FAULT} state_t;
`endif

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           drop_seen_reg, drop_seen_next;
    logic           drop_reg;
    logic           flag_reg;
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           overflow_reg;
    logic           motor_reg, coin_reg, busy_reg, fault_reg;
    logic           mem [DEPTH];

    logic pop, push, full, coin_next;

    assign pop  = (state_reg == IDLE) && (count_reg != '0);
    assign full = (count_reg == (AW+1)'(DEPTH));
    assign push = sell && (!full || pop);

    // Order storage: one change bit per entry, head read registered on pop.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= change;
        if (pop)
            flag_reg <= mem[rd_ptr_reg];
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        drop_seen_next = drop_seen_reg;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    state_next     = VEND;
                    cnt_next       = '0;
                    drop_seen_next = 1'b0;
                end
            end
            VEND: begin
                if (drop_reg)
                    drop_seen_next = 1'b1;
                if (cnt_reg == CW'(MOTOR_CYC - 1)) begin
                    cnt_next = '0;
                    if (drop_seen_reg || drop_reg)
                        state_next = flag_reg ? CHANGE : IDLE;
                    else
                        state_next = WAIT_DROP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            WAIT_DROP: begin
                // A drop presented on the expiry edge takes priority over the timeout.
                if (drop_reg) begin
                    state_next = flag_reg ? CHANGE : IDLE;
                end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    cnt_next = '0;
`ifdef DISPENSER_REFUND_EN
                    state_next = REFUND;
`else
                    state_next = FAULT;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            CHANGE: state_next = IDLE;
`ifdef DISPENSER_REFUND_EN
            REFUND: begin
                // Even counts are pulse-high cycles; 4 or 5 pulses depending on the change flag.
                if (cnt_reg == (flag_reg ? CW'(9) : CW'(7)))
                    state_next = FAULT;
                else
                    cnt_next = cnt_reg + 1'b1;
            end
`endif
            FAULT: begin
                if (fault_clr)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef DISPENSER_REFUND_EN
    assign coin_next = (state_next == CHANGE) || ((state_next == REFUND) && !cnt_next[0]);
`else
    assign coin_next = (state_next == CHANGE);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            drop_seen_reg <= 1'b0;
            drop_reg      <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            motor_reg     <= 1'b0;
            coin_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            drop_seen_reg <= drop_seen_next;
            // The sensor only matters while an item can actually be falling.
            drop_reg      <= item_drop && ((state_reg == VEND) || (state_reg == WAIT_DROP));
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg     <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
            if (sell && !push)
                overflow_reg <= 1'b1;
            motor_reg     <= (state_next == VEND);
            coin_reg      <= coin_next;
            busy_reg      <= (state_next != IDLE);
            fault_reg     <= (state_next == FAULT);
        end
    end

    assign motor    = motor_reg;
    assign coin_out = coin_reg;
    assign busy     = busy_reg;
    assign fault    = fault_reg;
    assign pending  = count_reg;
    assign overflow = overflow_reg;

endmodule
